// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/timing generator with frame-aligned run/stop.
// Ports:
//   clk, reset (async, active-high), en (run request, honoured on frame boundaries)
//   pixel_tick  - one-clk strobe every CLK_DIV clks
//   hsync/vsync - sync pulses at HSYNC_POL/VSYNC_POL while in the sync region
//   video_on    - (x,y) inside the active area while running
//   x, y        - pixel coordinates
//   line_start, frame_start - one-clk strobes at the first tick of each line/frame
//   running     - block is in RUN or STOP
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          pixel_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_ACT   = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_LAST = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_LAST = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t        r_state, w_state_n;
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_x, r_y, w_x_n, w_y_n;
    logic          r_hsync, r_vsync, r_video_on;
    logic          w_adv, w_last, w_run_n;

    assign pixel_tick  = (r_div == '0);
    assign running     = (r_state != IDLE);
    assign line_start  = pixel_tick && running && (r_x == '0);
    assign frame_start = line_start && (r_y == '0);
    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;

    always_comb begin
        w_adv   = pixel_tick && (r_state != IDLE);
        w_last  = (r_x == H_MAX) && (r_y == V_MAX);
        w_x_n   = w_adv ? ((r_x == H_MAX) ? '0 : r_x + CW'(1)) : r_x;
        w_y_n   = (w_adv && r_x == H_MAX) ? ((r_y == V_MAX) ? '0 : r_y + CW'(1)) : r_y;
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (pixel_tick && en) w_state_n = RUN;
            RUN:     if (!en) w_state_n = STOP;
            STOP:    if (en) w_state_n = RUN;
                     else if (pixel_tick && w_last) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
        w_run_n = (w_state_n != IDLE);
    end

    // Sync/video are registered from the next-state values so they line up with x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div      <= '0;
            r_state    <= IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= ~HS_ON;
            r_vsync    <= ~VS_ON;
            r_video_on <= 1'b0;
        end else begin
            r_div      <= (r_div == DIV_MAX) ? '0 : r_div + DW'(1);
            r_state    <= w_state_n;
            r_x        <= w_x_n;
            r_y        <= w_y_n;
            r_hsync    <= (w_run_n && w_x_n >= HS_BEG && w_x_n <= HS_LAST) ? HS_ON : ~HS_ON;
            r_vsync    <= (w_run_n && w_y_n >= VS_BEG && w_y_n <= VS_LAST) ? VS_ON : ~VS_ON;
            r_video_on <= w_run_n && (w_x_n < H_ACT) && (w_y_n < V_ACT);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three vga_timing_gen configurations against a linear-pixel-index reference model.
module tb_vga_timing_gen;
    typedef struct {
        int dv, hd, hf, hs, hb, vd, vf, vs, vb, hp, vp;
    } cfg_t;
    typedef struct {
        int md;
        int p;
        int c;
    } ms_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic chk_on = 1'b0;
    int   n_chk = 0, n_err = 0, cyc = 0;

    cfg_t ca = '{1, 8, 2, 3, 1, 4, 1, 1, 1, 1, 1};
    cfg_t cb = '{4, 20, 3, 5, 4, 12, 2, 2, 3, 0, 0};
    cfg_t cc = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
    ms_t  ma = '{0, 0, 0}, mb = '{0, 0, 0}, mc = '{0, 0, 0};

    logic       a_tick, a_hs, a_vs, a_vo, a_ls, a_fs, a_run;
    logic [3:0] a_x, a_y;
    logic       b_tick, b_hs, b_vs, b_vo, b_ls, b_fs, b_run;
    logic [5:0] b_x, b_y;
    logic       c_tick, c_hs, c_vs, c_vo, c_ls, c_fs, c_run;
    logic [9:0] c_x, c_y;

    vga_timing_gen #(.CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
                     .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .HSYNC_POL(1), .VSYNC_POL(1), .CW(4)) u_a (
        .clk(clk), .reset(reset), .en(en_a), .pixel_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_vo), .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .running(a_run));

    vga_timing_gen #(.CLK_DIV(4), .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
                     .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
                     .HSYNC_POL(0), .VSYNC_POL(0), .CW(6)) u_b (
        .clk(clk), .reset(reset), .en(en_b), .pixel_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_vo), .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .running(b_run));

    vga_timing_gen u_c (
        .clk(clk), .reset(reset), .en(en_c), .pixel_tick(c_tick), .hsync(c_hs), .vsync(c_vs),
        .video_on(c_vo), .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs), .running(c_run));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Model: mode (0 idle, 1 run, 2 stop), linear pixel index within the frame, clk phase.
    function automatic ms_t step(cfg_t g, ms_t m, logic e);
        int  n = (g.hd + g.hf + g.hs + g.hb) * (g.vd + g.vf + g.vs + g.vb);
        bit  tk = (m.c == 0);
        ms_t r = m;
        r.c = (m.c + 1) % g.dv;
        if (m.md == 0) begin
            if (tk && e) r.md = 1;
        end else begin
            if (tk) r.p = (m.p + 1) % n;
            if (m.md == 1 && !e) r.md = 2;
            else if (m.md == 2 && e) r.md = 1;
            else if (m.md == 2 && tk && m.p == n - 1) r.md = 0;
        end
        return r;
    endfunction

    function automatic logic [31:0] expo(cfg_t g, ms_t m);
        int   ht = g.hd + g.hf + g.hs + g.hb;
        int   px = m.p % ht, py = m.p / ht;
        bit   run = (m.md != 0), tk = (m.c == 0);
        bit   hs = run && px >= g.hd + g.hf && px < g.hd + g.hf + g.hs;
        bit   vs = run && py >= g.vd + g.vf && py < g.vd + g.vf + g.vs;
        bit   vo = run && px < g.hd && py < g.vd;
        bit   ls = tk && run && px == 0;
        bit   fs = ls && py == 0;
        bit   hl = hs ? (g.hp != 0) : (g.hp == 0);
        bit   vl = vs ? (g.vp != 0) : (g.vp == 0);
        logic [11:0] xx = 12'(px), yy = 12'(py);
        return {1'b0, tk, hl, vl, vo, ls, fs, run, yy, xx};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma = '{0, 0, 0};
            mb = '{0, 0, 0};
            mc = '{0, 0, 0};
        end else begin
            ma = step(ca, ma, en_a);
            mb = step(cb, mb, en_b);
            mc = step(cc, mc, en_c);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_a", {1'b0, a_tick, a_hs, a_vs, a_vo, a_ls, a_fs, a_run, 12'(a_y), 12'(a_x)}, expo(ca, ma));
            chk("model_b", {1'b0, b_tick, b_hs, b_vs, b_vo, b_ls, b_fs, b_run, 12'(b_y), 12'(b_x)}, expo(cb, mb));
            chk("model_c", {1'b0, c_tick, c_hs, c_vs, c_vo, c_ls, c_fs, c_run, 12'(c_y), 12'(c_x)}, expo(cc, mc));
        end
    end

    task automatic wait_hi(input string tag, input int which, input int v, input int lim, output int t);
        logic s;
        t = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            case (which)
                0:       s = a_fs;
                1:       s = a_ls;
                2:       s = b_fs;
                3:       s = b_run;
                4:       s = !b_run;
                5:       s = (32'(b_y) == v);
                6:       s = (32'(b_y) * 100 + 32'(b_x) == v);
                7:       s = c_ls;
                default: s = 1'b0;
            endcase
            if (s) begin
                t = cyc;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(t >= 0), 32'd1);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_a"}, 32'({a_run, a_vo, a_hs, a_vs, a_ls, a_fs, 4'(a_x), 4'(a_y)}), 32'(0));
        chk({tag, "_b"}, 32'({b_run, b_vo, b_hs, b_vs, b_ls, b_fs, 6'(b_x), 6'(b_y)}), 32'({2'b00, 2'b11, 2'b00, 12'd0}));
        chk({tag, "_c"}, 32'({c_run, c_vo, c_hs, c_vs, c_ls, c_fs, 10'(c_x), 10'(c_y)}), 32'({2'b00, 2'b11, 2'b00, 20'd0}));
    endtask

    initial begin
        int t0, t1, n, nh, nv, hf, hl, cnt;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk_on = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) chk_rst("rst_init");
            chk("tick_b", 32'(b_tick), 32'(k % 4 == 0));
            chk("tick_a", 32'(a_tick), 32'd1);
        end
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        repeat (37) @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_rst("rst_mid");
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("tick_after_rst", 32'({a_tick, b_tick, c_tick}), 32'd7);

        wait_hi("a_fs", 0, 0, 300, t0);
        wait_hi("a_fs", 0, 0, 300, t1);
        chk("a_frame", 32'(t1 - t0), 32'd98);
        wait_hi("a_ls", 1, 0, 100, t0);
        wait_hi("a_ls", 1, 0, 100, t1);
        chk("a_line", 32'(t1 - t0), 32'd14);
        wait_hi("b_fs", 2, 0, 6000, t0);
        wait_hi("b_fs", 2, 0, 6000, t1);
        chk("b_frame", 32'(t1 - t0), 32'd2432);

        wait_hi("c_ls", 7, 0, 10000, t0);
        n = 0; nh = 0; nv = 0; hf = -1; hl = -1;
        for (int i = 0; i < 3200; i++) begin
            if (i > 0) @(negedge clk);
            if (c_tick) begin
                n++;
                if (c_vo) nv++;
                if (!c_hs) begin
                    nh++;
                    if (hf < 0) hf = 32'(c_x);
                    hl = 32'(c_x);
                end
            end
        end
        @(negedge clk);
        chk("c_line_wrap", 32'({c_ls, 10'(c_x)}), 32'h400);
        chk("c_line_ticks", 32'(n), 32'd800);
        chk("c_hs_ticks", 32'(nh), 32'd96);
        chk("c_hs_first", 32'(hf), 32'd656);
        chk("c_hs_last", 32'(hl), 32'd751);
        chk("c_vo_ticks", 32'(nv), 32'd640);

        wait_hi("b_y5", 5, 5, 3000, t0);
        en_b = 1'b0;
        wait_hi("b_idle", 4, 0, 6000, t1);
        chk("b_stop_xy", 32'({6'(b_x), 6'(b_y)}), 32'd0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b_ls) cnt++;
        end
        chk("b_idle_ls", 32'(cnt), 32'd0);
        en_b = 1'b1;
        wait_hi("b_run", 3, 0, 20, t0);
        wait_hi("b_fs", 2, 0, 20, t1);
        chk("b_fs_lag", 32'(t1 - t0), 32'd3);

        wait_hi("b_fs", 2, 0, 6000, t0);
        wait_hi("b_y4", 5, 4, 3000, t1);
        en_b = 1'b0;
        wait_hi("b_y8", 5, 8, 3000, t1);
        en_b = 1'b1;
        chk("b_resume_run", 32'(b_run), 32'd1);
        wait_hi("b_fs", 2, 0, 6000, t1);
        chk("b_period", 32'(t1 - t0), 32'd2432);

        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 199) == 0) en_a = !en_a;
            if ($urandom_range(0, 199) == 0) en_b = !en_b;
            if ($urandom_range(0, 199) == 0) en_c = !en_c;
            if ($urandom_range(0, 3999) == 0) begin
                reset = 1'b1;
                @(posedge clk);
                #2 reset = 1'b0;
            end
        end

        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        wait_hi("b_mid", 6, 1016, 8000, t0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_rst("rst_frame");
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("b_restart_idle", 32'({b_run, 6'(b_x), 6'(b_y)}), 32'd0);
        wait_hi("b_restart", 3, 0, 20, t1);
        chk("b_restart_xy", 32'({6'(b_x), 6'(b_y)}), 32'd0);
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
